// File: rtl/ps2_drive_decoder.sv
// PS/2 keyboard receiver and scan-code decoder.
// Turns held arrow/WASD/space keys into steering, throttle and boost codes.
module ps2_drive_decoder #(
   parameter int CLK_FREQ       = 100_000_000,
   parameter int TIMEOUT_CYCLES = CLK_FREQ / 500
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [1:0] h_code,
   output logic [1:0] v_code,
   output logic       boost,
   output logic       byte_valid,
   output logic [7:0] scan_byte,
   output logic       frame_err
);

   typedef enum logic {
      RX_IDLE,
      RX_SHIFT
   } rx_state_t;

   typedef enum logic [1:0] {
      P_IDLE,
      P_E0,
      P_F0,
      P_E0F0
   } p_state_t;

   localparam int K_L  = 0;
   localparam int K_R  = 1;
   localparam int K_U  = 2;
   localparam int K_D  = 3;
   localparam int K_A  = 4;
   localparam int K_DK = 5;
   localparam int K_W  = 6;
   localparam int K_S  = 7;
   localparam int K_SP = 8;

   logic ck_s1_q, ck_s2_q, ck_prev_q;
   logic d_s1_q, d_s2_q;
   logic fall, bit_in;

   rx_state_t   rx_q, rx_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [8:0]  sh_q, sh_d;
   logic [31:0] tmo_q, tmo_d;
   logic        bv_q, bv_d;
   logic        fe_q, fe_d;
   logic [7:0]  scan_q, scan_d;

   p_state_t   p_q, p_d;
   logic [8:0] keys_q, keys_d;
   logic       ext, mk;

   logic [1:0] h_q, h_d;
   logic [1:0] v_q, v_d;
   logic       boost_q, boost_d;
   logic       l_any, r_any, u_any, d_any;

   // Two-flop synchronizers plus one delay stage for clock edge detection.
   // Reset to 0 so a pin held high at release never looks like an edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ck_s1_q   <= 1'b0;
         ck_s2_q   <= 1'b0;
         ck_prev_q <= 1'b0;
         d_s1_q    <= 1'b0;
         d_s2_q    <= 1'b0;
      end else begin
         ck_s1_q   <= ps2_clk;
         ck_s2_q   <= ck_s1_q;
         ck_prev_q <= ck_s2_q;
         d_s1_q    <= ps2_data;
         d_s2_q    <= d_s1_q;
      end
   end

   assign fall   = ck_prev_q & ~ck_s2_q;
   assign bit_in = d_s2_q;

   // Receiver state and shift registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_q   <= RX_IDLE;
         cnt_q  <= 4'd0;
         sh_q   <= 9'd0;
         tmo_q  <= 32'd0;
         bv_q   <= 1'b0;
         fe_q   <= 1'b0;
         scan_q <= 8'd0;
      end else begin
         rx_q   <= rx_d;
         cnt_q  <= cnt_d;
         sh_q   <= sh_d;
         tmo_q  <= tmo_d;
         bv_q   <= bv_d;
         fe_q   <= fe_d;
         scan_q <= scan_d;
      end
   end

   // Frame reception: LSB-first shift, odd parity and stop check, idle timeout.
   // Bits enter at the MSB so after nine shifts data sits in [7:0], parity in [8].
   always_comb begin
      rx_d   = rx_q;
      cnt_d  = cnt_q;
      sh_d   = sh_q;
      tmo_d  = tmo_q;
      bv_d   = 1'b0;
      fe_d   = 1'b0;
      scan_d = scan_q;
      unique case (rx_q)
         RX_IDLE: begin
            if (fall && !bit_in) begin
               rx_d  = RX_SHIFT;
               cnt_d = 4'd0;
               tmo_d = 32'd0;
            end
         end
         RX_SHIFT: begin
            if (fall) begin
               tmo_d = 32'd0;
               if (cnt_q == 4'd9) begin
                  rx_d = RX_IDLE;
                  if (bit_in && (^sh_q)) begin
                     bv_d   = 1'b1;
                     scan_d = sh_q[7:0];
                  end else begin
                     fe_d = 1'b1;
                  end
               end else begin
                  sh_d  = {bit_in, sh_q[8:1]};
                  cnt_d = cnt_q + 4'd1;
               end
            end else if (tmo_q >= 32'(TIMEOUT_CYCLES)) begin
               rx_d = RX_IDLE;
            end else begin
               tmo_d = tmo_q + 32'd1;
            end
         end
      endcase
   end

   // Prefix state and per-key held bits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_q    <= P_IDLE;
         keys_q <= 9'd0;
      end else begin
         p_q    <= p_d;
         keys_q <= keys_d;
      end
   end

   assign ext = (p_q == P_E0) || (p_q == P_E0F0);
   assign mk  = !((p_q == P_F0) || (p_q == P_E0F0));

   // Prefix tracking; any non-prefix byte is applied as a make or break.
   always_comb begin
      p_d    = p_q;
      keys_d = keys_q;
      if (bv_q) begin
         if (scan_q == 8'hE0 && p_q == P_IDLE) begin
            p_d = P_E0;
         end else if (scan_q == 8'hF0 && p_q == P_IDLE) begin
            p_d = P_F0;
         end else if (scan_q == 8'hF0 && p_q == P_E0) begin
            p_d = P_E0F0;
         end else begin
            p_d = P_IDLE;
            unique case (1'b1)
               ext  && scan_q == 8'h6B: keys_d[K_L]  = mk;
               ext  && scan_q == 8'h74: keys_d[K_R]  = mk;
               ext  && scan_q == 8'h75: keys_d[K_U]  = mk;
               ext  && scan_q == 8'h72: keys_d[K_D]  = mk;
               !ext && scan_q == 8'h1C: keys_d[K_A]  = mk;
               !ext && scan_q == 8'h23: keys_d[K_DK] = mk;
               !ext && scan_q == 8'h1D: keys_d[K_W]  = mk;
               !ext && scan_q == 8'h1B: keys_d[K_S]  = mk;
               !ext && scan_q == 8'h29: keys_d[K_SP] = mk;
               default: ;
            endcase
         end
      end
   end

   assign l_any = keys_q[K_L] | keys_q[K_A];
   assign r_any = keys_q[K_R] | keys_q[K_DK];
   assign u_any = keys_q[K_U] | keys_q[K_W];
   assign d_any = keys_q[K_D] | keys_q[K_S];

   // Opposing directions cancel to 0.
   always_comb begin
      h_d     = 2'd0;
      v_d     = 2'd0;
      boost_d = keys_q[K_SP];
      if (l_any && !r_any) h_d = 2'd1;
      if (r_any && !l_any) h_d = 2'd2;
      if (u_any && !d_any) v_d = 2'd1;
      if (d_any && !u_any) v_d = 2'd2;
   end

   // Registered outputs so the physics engine never sees decode glitches.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         h_q     <= 2'd0;
         v_q     <= 2'd0;
         boost_q <= 1'b0;
      end else begin
         h_q     <= h_d;
         v_q     <= v_d;
         boost_q <= boost_d;
      end
   end

   assign h_code     = h_q;
   assign v_code     = v_q;
   assign boost      = boost_q;
   assign byte_valid = bv_q;
   assign scan_byte  = scan_q;
   assign frame_err  = fe_q;

endmodule

// File: tb/tb_ps2_drive_decoder.sv
// Directed bench for ps2_drive_decoder.
// Frame pulses are scoreboarded; key outputs are checked after each frame.
module tb_ps2_drive_decoder;

   localparam int TMO = 300;
   localparam int H   = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [1:0] h_code;
   logic [1:0] v_code;
   logic       boost;
   logic       byte_valid;
   logic [7:0] scan_byte;
   logic       frame_err;

   int checks = 0;
   int errors = 0;

   logic [9:0]  exp_q[$];
   logic [9:0]  obs_q[$];
   logic [7:0]  exp_scan = 8'h00;
   logic [10:0] rbits;

   ps2_drive_decoder #(
      .CLK_FREQ(100_000_000),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .ps2_clk(ps2_clk),
      .ps2_data(ps2_data),
      .h_code(h_code),
      .v_code(v_code),
      .boost(boost),
      .byte_valid(byte_valid),
      .scan_byte(scan_byte),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (rst && (byte_valid || frame_err))
         obs_q.push_back({frame_err, byte_valid, scan_byte});

   initial begin
      #2ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [1:0] h,
                          input logic [1:0] v, input logic b);
      chk(tag, {11'd0, h_code, v_code, boost}, {11'd0, h, v, b});
   endtask

   function automatic logic [10:0] mkframe(input logic [7:0] b,
                                           input logic bad);
      return {1'b1, (~^b) ^ bad, b, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] bits, input int lo,
                            input int hi);
      for (int i = lo; i <= hi; i++) begin
         ps2_data = bits[i];
         tick(H);
         ps2_clk = 1'b0;
         if (i < hi) begin
            tick(H);
            ps2_clk = 1'b1;
         end
      end
   endtask

   task automatic send(input logic [7:0] b, input logic bad);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      tick(2 * H);
      send_bits(mkframe(b, bad), 0, 10);
      if (bad) begin
         exp_q.push_back({2'b10, exp_scan});
      end else begin
         exp_scan = b;
         exp_q.push_back({2'b01, b});
      end
      tick(6);
   endtask

   task automatic drain(input string tag);
      logic [9:0] e;
      logic [9:0] o;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 10'h3FF;
         chk(tag, {6'd0, o}, {6'd0, e});
      end
      chk({tag, "_extra"}, 16'(obs_q.size()), 16'd0);
      obs_q.delete();
   endtask

   initial begin
      tick(3);
      chk("reset", {1'b0, h_code, v_code, boost, byte_valid, frame_err,
                    scan_byte}, 16'd0);
      rst = 1'b1;
      tick(3);

      send(8'hE0, 1'b0);
      send(8'h6B, 1'b0);
      chk_out("left_make", 2'd1, 2'd0, 1'b0);
      send(8'hE0, 1'b0);
      send(8'hF0, 1'b0);
      send(8'h6B, 1'b0);
      chk_out("left_break", 2'd0, 2'd0, 1'b0);
      drain("ev_left");

      send(8'h1C, 1'b0);
      chk_out("a_make", 2'd1, 2'd0, 1'b0);
      send(8'h23, 1'b0);
      chk_out("a_d_both", 2'd0, 2'd0, 1'b0);
      send(8'hF0, 1'b0);
      send(8'h1C, 1'b0);
      chk_out("a_break", 2'd2, 2'd0, 1'b0);
      drain("ev_ad");

      send(8'h1D, 1'b0);
      send(8'h29, 1'b0);
      chk_out("w_space", 2'd2, 2'd1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         send(8'h1D, 1'b0);
         chk_out("w_repeat", 2'd2, 2'd1, 1'b1);
      end
      send(8'hF0, 1'b0);
      send(8'h29, 1'b0);
      chk_out("space_brk", 2'd2, 2'd1, 1'b0);
      drain("ev_ws");

      send(8'hF0, 1'b0);
      send(8'h1D, 1'b0);
      chk_out("w_break", 2'd2, 2'd0, 1'b0);
      send(8'h75, 1'b1);
      chk_out("bad_par", 2'd2, 2'd0, 1'b0);
      drain("ev_badpar");
      send(8'hE0, 1'b0);
      send(8'h75, 1'b0);
      chk_out("up_make", 2'd2, 2'd1, 1'b0);
      send(8'hE0, 1'b0);
      send(8'hF0, 1'b0);
      send(8'h75, 1'b0);
      chk_out("up_break", 2'd2, 2'd0, 1'b0);
      drain("ev_up");

      ps2_clk = 1'b1;
      tick(2 * H);
      send_bits(mkframe(8'h75, 1'b0), 0, 4);
      ps2_clk = 1'b1;
      tick(TMO + 10);
      drain("ev_timeout");
      send(8'hE0, 1'b0);
      send(8'h72, 1'b0);
      chk_out("down_make", 2'd2, 2'd2, 1'b0);
      drain("ev_down");

      ps2_clk = 1'b1;
      tick(2 * H);
      rbits = mkframe(8'h6B, 1'b0);
      send_bits(rbits, 0, 3);
      ps2_clk = 1'b1;
      tick(H);
      rst = 1'b0;
      #1;
      chk("rst_async", {1'b0, h_code, v_code, boost, byte_valid, frame_err,
                        scan_byte}, 16'd0);
      tick(2);
      rst = 1'b1;
      tick(2);
      for (int i = 4; i <= 10; i++) begin
         ps2_data = rbits[i];
         tick(H);
         ps2_clk = 1'b0;
         tick(H);
         ps2_clk = 1'b1;
      end
      tick(TMO + 10);
      drain("ev_rst");
      chk("rst_after", {1'b0, h_code, v_code, boost, byte_valid, frame_err,
                        scan_byte}, 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
